vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/sync_edge_det.sv | 30 +++
 rtl/vga_sync_decoder.sv | 193 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, sync-decoder state encoding,
// per-sample event bundle and counter helper shared by decoder and generator.
package vga_timing_pkg;

  localparam int H_TOTAL_640  = 800;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int H_ACTIVE_640 = 640;
  localparam int V_TOTAL_480  = 525;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;
  localparam int V_ACTIVE_480 = 480;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_e;

  typedef struct packed {
    logic h_edge;
    logic frame;
    logic h_err;
    logic v_err;
  } sync_evt_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: holds the asserted/deasserted state of the last enabled
// sample of a sync line and flags an assertion edge on the incoming sample.
// Ports: board_clk/reset (async, active-high), en_i (capture enable),
// sync_i (raw sync level), edge_o (asserted now, deasserted last capture).
module sync_edge_det #(
  parameter logic POL = 1'b0
) (
  input  logic board_clk,
  input  logic reset,
  input  logic en_i,
  input  logic sync_i,
  output logic edge_o
);

  logic act_d;
  logic act_q;

  assign act_d  = (sync_i == POL);
  assign edge_o = act_d & ~act_q;

  // Reset value 0 means "deasserted", whatever the polarity.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      act_q <= 1'b0;
    end else if (en_i) begin
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from a VGA hsync/vsync/rgb
// stream sampled at pix_ce, checks line/frame lengths and tracks lock.
// Ports: board_clk, reset (async, active-high), pix_ce (pixel enable),
// vga_h_sync/vga_v_sync/vga_rgb (stream in), pix_valid/pix_x/pix_y/pix_rgb
// (decoded pixel), frame_start, locked, h_err, v_err (status).
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int   H_TOTAL  = H_TOTAL_640,
  parameter int   H_SYNC   = H_SYNC_640,
  parameter int   H_BP     = H_BP_640,
  parameter int   H_ACTIVE = H_ACTIVE_640,
  parameter int   V_TOTAL  = V_TOTAL_480,
  parameter int   V_SYNC   = V_SYNC_480,
  parameter int   V_BP     = V_BP_480,
  parameter int   V_ACTIVE = V_ACTIVE_480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  input  logic [2:0] vga_rgb,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_LO   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_HI   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_HI   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic              h_edge;
  logic              v_edge;
  sync_evt_t         evt;
  logic              any_err;

  logic [CNT_W-1:0]  h_cnt_q;
  logic [CNT_W-1:0]  h_cnt_d;
  logic [CNT_W-1:0]  v_cnt_q;
  logic [CNT_W-1:0]  v_cnt_d;

  sync_state_e       state_q;
  sync_state_e       state_d;
  logic              chk_err_q;
  logic              chk_err_d;

  logic              locked_c;
  logic              vis_c;

  sync_edge_det #(
    .POL    (SYNC_POL)
  ) u_hs_det (
    .board_clk (board_clk),
    .reset     (reset),
    .en_i      (pix_ce),
    .sync_i    (vga_h_sync),
    .edge_o    (h_edge)
  );

  // vsync is only looked at on hsync edges, so its "previous" sample is
  // the level seen at the previous hsync edge.
  sync_edge_det #(
    .POL    (SYNC_POL)
  ) u_vs_det (
    .board_clk (board_clk),
    .reset     (reset),
    .en_i      (pix_ce & h_edge),
    .sync_i    (vga_v_sync),
    .edge_o    (v_edge)
  );

  // A saturated counter is always an error, even if it aliases the target.
  always_comb begin
    evt        = '0;
    evt.h_edge = pix_ce & h_edge;
    evt.frame  = evt.h_edge & v_edge;
    evt.h_err  = evt.h_edge &
                 ((h_cnt_q != H_LAST) | (h_cnt_q == CNT_MAX));
    evt.v_err  = evt.frame &
                 ((v_cnt_q != V_LAST) | (v_cnt_q == CNT_MAX));
  end

  assign any_err = evt.h_err | evt.v_err;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      h_cnt_d = evt.h_edge ? '0 : sat_inc(h_cnt_q);
      if (evt.frame) begin
        v_cnt_d = '0;
      end else if (evt.h_edge) begin
        v_cnt_d = sat_inc(v_cnt_q);
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      chk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chk_err_q <= chk_err_d;
    end
  end

  // Errors on the boundary that closes a CHECK frame still veto the lock.
  always_comb begin
    state_d   = state_q;
    chk_err_d = chk_err_q;
    unique case (state_q)
      ST_HUNT: begin
        if (evt.frame) begin
          state_d   = ST_CHECK;
          chk_err_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (evt.frame) begin
          chk_err_d = 1'b0;
          if (!chk_err_q && !any_err) begin
            state_d = ST_LOCKED;
          end
        end else if (any_err) begin
          chk_err_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          state_d = ST_HUNT;
        end
      end
      default: begin
        state_d   = ST_HUNT;
        chk_err_d = 1'b0;
      end
    endcase
  end

  // Window is judged on the counts that describe the incoming sample.
  always_comb begin
    locked_c = (state_q == ST_LOCKED);
    vis_c    = pix_ce & locked_c &
               (h_cnt_d >= H_LO) & (h_cnt_d < H_HI) &
               (v_cnt_d >= V_LO) & (v_cnt_d < V_HI);
  end

  assign locked = locked_c;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      pix_valid   <= vis_c;
      frame_start <= evt.frame;
      h_err       <= evt.h_err;
      v_err       <= evt.v_err;
      if (vis_c) begin
        pix_x   <= h_cnt_d - H_LO;
        pix_y   <= v_cnt_d - V_LO;
        pix_rgb <= vga_rgb;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized-gap stream generator with a sample-level
// reference model feeding a scoreboard; a monitor checks every DUT strobe.
module tb_vga_sync_decoder;

  localparam int HT = 32;
  localparam int HS = 3;
  localparam int HB = 5;
  localparam int HA = 20;
  localparam int VT = 16;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 8;
  localparam logic POL = 1'b0;

  logic       board_clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic [2:0] vga_rgb;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [2:0] pix_rgb;
  logic       frame_start;
  logic       locked;
  logic       h_err;
  logic       v_err;

  vga_sync_decoder #(
    .H_TOTAL (HT), .H_SYNC (HS), .H_BP (HB), .H_ACTIVE (HA),
    .V_TOTAL (VT), .V_SYNC (VS), .V_BP (VB), .V_ACTIVE (VA),
    .SYNC_POL (POL)
  ) dut (
    .board_clk   (board_clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .vga_h_sync  (vga_h_sync),
    .vga_v_sync  (vga_v_sync),
    .vga_rgb     (vga_rgb),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .h_err       (h_err),
    .v_err       (v_err)
  );

  always #5 board_clk = ~board_clk;

  int cyc = 0;
  always @(posedge board_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         pv;
    bit         fs;
    bit         he;
    bit         ve;
    bit         lk;
    int         x;
    int         y;
    logic [2:0] rgb;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: position since the last hsync edge and lines since
  // the last frame boundary, kept as unbounded sample/line numbers.
  int m_n;
  int m_last_he;
  int m_lines;
  int m_phase;
  bit m_prev_hs;
  bit m_prev_vs;
  bit m_bad;

  task automatic model_reset();
    m_n       = 0;
    m_last_he = -1;
    m_lines   = 0;
    m_phase   = 0;
    m_prev_hs = 1'b0;
    m_prev_vs = 1'b0;
    m_bad     = 1'b0;
  endtask

  task automatic model_step(input logic hs, input logic vs,
                            input logic [2:0] rgb);
    exp_t e;
    bit   ha, va, hedge, bnd, he, ve, lk0;
    int   prior_h, prior_v, h, v;
    ha      = (hs == POL);
    va      = (vs == POL);
    hedge   = ha && !m_prev_hs;
    m_prev_hs = ha;
    prior_h = m_n - 1 - m_last_he;
    if (prior_h > 1023) prior_h = 1023;
    prior_v = (m_lines > 1023) ? 1023 : m_lines;
    bnd     = hedge && va && !m_prev_vs;
    he      = hedge && (prior_h != HT - 1 || prior_h == 1023);
    ve      = bnd && (prior_v != VT - 1 || prior_v == 1023);
    if (hedge) begin
      m_prev_vs = va;
      m_last_he = m_n;
      m_lines   = bnd ? 0 : m_lines + 1;
    end
    h = m_n - m_last_he;
    if (h > 1023) h = 1023;
    v = (m_lines > 1023) ? 1023 : m_lines;
    lk0 = (m_phase == 2);
    case (m_phase)
      0: if (bnd) begin m_phase = 1; m_bad = 1'b0; end
      1: begin
        if (bnd) begin
          if (!m_bad && !he && !ve) m_phase = 2;
          m_bad = 1'b0;
        end else if (he || ve) begin
          m_bad = 1'b1;
        end
      end
      default: if (he || ve) m_phase = 0;
    endcase
    e.cyc = cyc + 1;
    e.pv  = lk0 && h >= HS + HB && h < HS + HB + HA &&
            v >= VS + VB && v < VS + VB + VA;
    e.fs  = bnd;
    e.he  = he;
    e.ve  = ve;
    e.lk  = (m_phase == 2);
    e.x   = h - (HS + HB);
    e.y   = v - (VS + VB);
    e.rgb = rgb;
    if (e.pv || e.fs || e.he || e.ve) q.push_back(e);
    m_n++;
  endtask

  // Monitor
  exp_t       me;
  int         lx = 0;
  int         ly = 0;
  logic [2:0] lrgb = '0;
  int         fpix = 0;
  bit         whole = 1'b0;
  bit         dir00 = 1'b0;

  always @(negedge board_clk) begin
    if (reset) begin
      lx = 0; ly = 0; lrgb = '0; fpix = 0; whole = 1'b0;
    end else begin
      if (pix_valid | frame_start | h_err | v_err) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe cyc=%0d pv=%b fs=%b he=%b ve=%b",
                   cyc, pix_valid, frame_start, h_err, v_err);
        end else begin
          me = q.pop_front();
          if (me.cyc != cyc || me.pv != pix_valid || me.fs != frame_start ||
              me.he != h_err || me.ve != v_err || me.lk != locked ||
              (me.pv && (pix_x !== 10'(me.x) || pix_y !== 10'(me.y) ||
                         pix_rgb !== me.rgb))) begin
            fails++;
            $display("FAIL event got cyc=%0d pv=%b fs=%b he=%b ve=%b lk=%b x=%0d y=%0d rgb=%b required cyc=%0d pv=%b fs=%b he=%b ve=%b lk=%b x=%0d y=%0d rgb=%b",
                     cyc, pix_valid, frame_start, h_err, v_err, locked,
                     pix_x, pix_y, pix_rgb, me.cyc, me.pv, me.fs, me.he,
                     me.ve, me.lk, me.x, me.y, me.rgb);
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        me = q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_event got none at cyc=%0d required pv=%b fs=%b he=%b ve=%b due cyc=%0d",
                 cyc, me.pv, me.fs, me.he, me.ve, me.cyc);
      end
      if (!pix_valid) begin
        tests++;
        if (pix_x !== 10'(lx) || pix_y !== 10'(ly) || pix_rgb !== lrgb) begin
          fails++;
          $display("FAIL hold_stable got x=%0d y=%0d rgb=%b required x=%0d y=%0d rgb=%b",
                   pix_x, pix_y, pix_rgb, lx, ly, lrgb);
        end
      end else begin
        lx = int'(pix_x); ly = int'(pix_y); lrgb = pix_rgb;
        fpix++;
        if (dir00 && pix_x == 10'd0 && pix_y == 10'd0) begin
          tests++;
          if (pix_rgb !== 3'b101) begin
            fails++;
            $display("FAIL first_pixel_rgb got %b required 101", pix_rgb);
          end
        end
      end
      if (frame_start) begin
        if (whole) begin
          tests++;
          if (fpix != HA * VA) begin
            fails++;
            $display("FAIL pixels_per_frame got %0d required %0d",
                     fpix, HA * VA);
          end
        end
        whole = locked;
        fpix  = 0;
      end
      if (!locked) whole = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s got %0d required %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pix_valid"},   32'(pix_valid),   0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_locked"},      32'(locked),      0);
    chk({tag, "_h_err"},       32'(h_err),       0);
    chk({tag, "_v_err"},       32'(v_err),       0);
    chk({tag, "_pix_x"},       32'(pix_x),       0);
    chk({tag, "_pix_y"},       32'(pix_y),       0);
    chk({tag, "_pix_rgb"},     32'(pix_rgb),     0);
  endtask

  // Idle cycles carry random garbage that must be ignored.
  task automatic send(input logic hs, input logic vs, input logic [2:0] rgb);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(negedge board_clk);
      pix_ce     = 1'b0;
      vga_h_sync = 1'($urandom);
      vga_v_sync = 1'($urandom);
      vga_rgb    = 3'($urandom);
    end
    @(negedge board_clk);
    pix_ce     = 1'b1;
    vga_h_sync = hs;
    vga_v_sync = vs;
    vga_rgb    = rgb;
    model_step(hs, vs, rgb);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge board_clk);
      pix_ce = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(2);
    chk("queue_drained_before_reset", 32'(q.size()), 0);
    reset = 1'b1;
    model_reset();
    q.delete();
    #1;
    chk_outputs_zero("midreset");
    repeat (3) @(negedge board_clk);
    reset = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int bad_line,
                            input int bad_len, input int voff,
                            input int rst_line);
    int         len, pos;
    logic       hs, vs;
    logic [2:0] c;
    dir00 = (voff == 0);
    pos   = 0;
    for (int l = 0; l < lines; l++) begin
      if (l == rst_line) do_reset();
      len = (l == bad_line) ? bad_len : HT;
      for (int p = 0; p < len; p++) begin
        hs = (p < HS) ? POL : ~POL;
        vs = (pos >= voff && pos < voff + VS * HT) ? POL : ~POL;
        c  = (l == VS + VB && p == HS + HB) ? 3'b101 : 3'($urandom);
        send(hs, vs, c);
        pos++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    pix_ce     = 1'b0;
    vga_h_sync = ~POL;
    vga_v_sync = ~POL;
    vga_rgb    = '0;
    model_reset();
    repeat (3) @(negedge board_clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    repeat (3) send_frame(VT, -1, 0, 0, -1);

    send_frame(VT, 7, HT - 1, 0, -1);
    repeat (3) send_frame(VT, -1, 0, 0, -1);

    send_frame(VT - 1, -1, 0, 0, -1);
    repeat (3) send_frame(VT, -1, 0, 0, -1);

    send_frame(VT - 1, -1, 0, 0, -1);
    send_frame(VT, -1, 0, 10, -1);
    send_frame(VT + 1, -1, 0, 10, -1);
    send_frame(VT, -1, 0, 0, -1);

    dir00 = 1'b0;
    repeat (300) send(1'($urandom), 1'($urandom), 3'($urandom));
    repeat (1100) send(~POL, ~POL, 3'($urandom));
    repeat (4) send_frame(VT, -1, 0, 0, -1);

    send_frame(VT, -1, 0, 0, 7);
    repeat (3) send_frame(VT, -1, 0, 0, -1);
    send_frame(2, -1, 0, 0, -1);

    idle(4);
    chk("queue_drained_at_end", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
